shift_split: RTL and testbench

//  Inverse of the shift-concatenation packer: accepts LSB-first packed 64-bit words and returns

---
 rtl/shift_split_if.sv | 32 +++
 rtl/shift_split.sv | 103 ++++++++++
 tb/tb_shift_split.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/shift_split_if.sv
// Bus bundle for shift_split: word input handshake, field request handshake,
// control (stall/flush) and status outputs.
interface shift_split_if #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned LEN_W  = 7,
  parameter int unsigned CNT_W  = 8
);
  logic              stall;
  logic              flush;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              req_valid;
  logic [LEN_W-1:0]  req_len;
  logic              req_ready;
  logic [WORD_W-1:0] data_out;
  logic              data_out_valid;
  logic [CNT_W-1:0]  buf_bits;
  logic              err;

  // Word source / field requester side
  modport master (
    output stall, flush, word_in, word_valid, req_valid, req_len,
    input  word_ready, req_ready, data_out, data_out_valid, buf_bits, err
  );

  // Splitter side
  modport slave (
    input  stall, flush, word_in, word_valid, req_valid, req_len,
    output word_ready, req_ready, data_out, data_out_valid, buf_bits, err
  );
endinterface

// File: rtl/shift_split.sv
// shift_split: unpacks LSB-first packed words into variable-length fields
// (1..WORD_W bits) using a 2*WORD_W holding buffer and a valid-bit counter.
// Buffer bit 0 is always the oldest unconsumed bit.
module shift_split #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned LEN_W  = 7,
  parameter int unsigned CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  shift_split_if.slave bus
);
  localparam int unsigned BUF_W = 2 * WORD_W;

  logic [BUF_W-1:0]  r_buf;
  logic [CNT_W-1:0]  r_buf_bits;
  logic [WORD_W-1:0] r_data_out;
  logic              r_data_out_valid;
  logic              r_err;

  logic [LEN_W-1:0]  w_req_len;
  logic [CNT_W-1:0]  w_len;
  logic              w_active;
  logic              w_len_ok;
  logic              w_word_ready;
  logic              w_req_ready;
  logic              w_load;
  logic              w_extract;
  logic [CNT_W-1:0]  w_take;
  logic [CNT_W-1:0]  w_ins_pos;
  logic [BUF_W-1:0]  w_word_ext;
  logic [BUF_W-1:0]  w_next_buf;
  logic [CNT_W-1:0]  w_next_bits;
  logic [WORD_W-1:0] w_mask;
  logic [WORD_W-1:0] w_field;

  // Handshake decode and next buffer contents
  always_comb begin
    w_req_len    = bus.req_len;
    w_len        = CNT_W'(w_req_len);
    w_active     = ~bus.stall & ~bus.flush;
    w_len_ok     = (w_len != '0) && (w_len <= CNT_W'(WORD_W));
    w_word_ready = w_active && (r_buf_bits <= CNT_W'(WORD_W));
    w_req_ready  = w_active && w_len_ok && (r_buf_bits >= w_len);
    w_load       = bus.word_valid & w_word_ready;
    w_extract    = bus.req_valid & w_req_ready;
    w_take       = w_extract ? w_len : '0;
    // New word goes directly above whatever survives this cycle's extract
    w_ins_pos    = r_buf_bits - w_take;
    w_word_ext   = {{WORD_W{1'b0}}, bus.word_in} << w_ins_pos;
    w_next_buf   = (r_buf >> w_take) | (w_load ? w_word_ext : '0);
    w_next_bits  = r_buf_bits - w_take + (w_load ? CNT_W'(WORD_W) : '0);
    w_mask       = {WORD_W{1'b1}} >> (CNT_W'(WORD_W) - w_len);
    w_field      = r_buf[WORD_W-1:0] & w_mask;
  end

  // Holding buffer and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf      <= '0;
      r_buf_bits <= '0;
    end else if (bus.stall) begin
      r_buf      <= r_buf;
      r_buf_bits <= r_buf_bits;
    end else if (bus.flush) begin
      r_buf      <= '0;
      r_buf_bits <= '0;
    end else begin
      r_buf      <= w_next_buf;
      r_buf_bits <= w_next_bits;
    end
  end

  // Registered field output; data_out keeps its last field when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else if (bus.stall) begin
      r_data_out_valid <= r_data_out_valid;
    end else if (bus.flush) begin
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= w_extract;
      if (w_extract) r_data_out <= w_field;
    end
  end

  // Sticky illegal-length flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_active && bus.req_valid && !w_len_ok)
      r_err <= 1'b1;
  end

  assign bus.word_ready     = w_word_ready;
  assign bus.req_ready      = w_req_ready;
  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_data_out_valid;
  assign bus.buf_bits       = r_buf_bits;
  assign bus.err            = r_err;
endmodule

// File: tb/tb_shift_split.sv
// Self-checking bench for shift_split: directed scenarios plus randomized
// traffic, compared against a bit-queue reference model.
module tb_shift_split;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_split_if #(.WORD_W(64), .LEN_W(7), .CNT_W(8)) bus ();

  shift_split #(.WORD_W(64), .LEN_W(7), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: queue of pending bits, oldest at the front
  bit          mq[$];
  logic [63:0] m_dout = '0;
  bit          m_dv   = 1'b0;
  bit          m_err  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock: drive inputs, check handshakes, advance model, check registers
  task automatic apply(input bit st, input bit fl, input bit wv, input logic [63:0] w,
                       input bit rv, input logic [6:0] len);
    bit          len_ok;
    bit          exp_wr;
    bit          exp_rr;
    logic [63:0] v;
    int          n;
    bus.stall      = st;
    bus.flush      = fl;
    bus.word_valid = wv;
    bus.word_in    = w;
    bus.req_valid  = rv;
    bus.req_len    = len;
    n      = mq.size();
    len_ok = (len >= 1) && (len <= 64);
    exp_wr = !st && !fl && (n <= 64);
    exp_rr = !st && !fl && len_ok && (n >= int'(len));
    #1;
    chk("word_ready", 64'(bus.word_ready), 64'(exp_wr));
    chk("req_ready",  64'(bus.req_ready),  64'(exp_rr));
    if (!st) begin
      if (fl) begin
        mq.delete();
        m_dv = 1'b0;
      end else begin
        if (rv && !len_ok) m_err = 1'b1;
        if (rv && exp_rr) begin
          v = '0;
          for (int i = 0; i < int'(len); i++) v[i] = mq.pop_front();
          m_dout = v;
          m_dv   = 1'b1;
        end else begin
          m_dv = 1'b0;
        end
        if (wv && exp_wr)
          for (int i = 0; i < 64; i++) mq.push_back(w[i]);
      end
    end
    @(posedge clk);
    #1;
    chk("data_out_valid", 64'(bus.data_out_valid), 64'(m_dv));
    chk("data_out",       bus.data_out,            m_dout);
    chk("buf_bits",       64'(bus.buf_bits),       64'(mq.size()));
    chk("err",            64'(bus.err),            64'(m_err));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.word_valid = 0; bus.word_in = '0;
    bus.req_valid = 0; bus.req_len = '0;
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("rst_data_out", bus.data_out, 64'h0);
    chk("rst_dv",       64'(bus.data_out_valid), 64'h0);
    chk("rst_buf_bits", 64'(bus.buf_bits), 64'h0);
    chk("rst_err",      64'(bus.err), 64'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [63:0] rw;
  logic [6:0]  rl;

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Test 1: basic extract from one word
    apply(0, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd4);
    chk("t1_f4",  bus.data_out, 64'hF);
    chk("t1_b60", 64'(bus.buf_bits), 64'd60);
    apply(0, 0, 0, '0, 1, 7'd8);
    chk("t1_f8",  bus.data_out, 64'hDE);
    chk("t1_b52", 64'(bus.buf_bits), 64'd52);

    // Test 2: field straddling two words
    apply(0, 1, 0, '0, 0, 0);
    apply(0, 0, 1, '1, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd60);
    chk("t2_f60", bus.data_out, 64'h0FFF_FFFF_FFFF_FFFF);
    chk("t2_b4",  64'(bus.buf_bits), 64'd4);
    apply(0, 0, 1, 64'h0, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd8);
    chk("t2_f8",  bus.data_out, 64'h0F);

    // Test 3: load and full-word extract in the same cycle at 64 bits
    apply(0, 1, 0, '0, 0, 0);
    apply(0, 0, 1, 64'hAAAA_5555_1234_8765, 0, 0);
    apply(0, 0, 1, 64'hFEDC_BA98_7654_3210, 1, 7'd64);
    chk("t3_w1",  bus.data_out, 64'hAAAA_5555_1234_8765);
    chk("t3_b64", 64'(bus.buf_bits), 64'd64);
    apply(0, 0, 0, '0, 1, 7'd64);
    chk("t3_w2",  bus.data_out, 64'hFEDC_BA98_7654_3210);

    // Test 4: back-pressure at 72 bits, released by an extract
    apply(0, 1, 0, '0, 0, 0);
    apply(0, 0, 1, 64'h1111_2222_3333_4444, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd56);
    apply(0, 0, 1, 64'h5555_6666_7777_8888, 0, 0);
    apply(0, 0, 1, 64'h9999_AAAA_BBBB_CCCC, 1, 7'd8);
    apply(0, 0, 1, 64'h9999_AAAA_BBBB_CCCC, 0, 0);
    chk("t4_b128", 64'(bus.buf_bits), 64'd128);

    // Test 5: underflow and illegal length
    apply(0, 1, 0, '0, 0, 0);
    apply(0, 0, 1, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd61);
    apply(0, 0, 0, '0, 1, 7'd5);
    chk("t5_noerr", 64'(bus.err), 64'd0);
    apply(0, 0, 0, '0, 1, 7'd70);
    chk("t5_err",   64'(bus.err), 64'd1);
    chk("t5_b3",    64'(bus.buf_bits), 64'd3);
    apply(0, 0, 0, '0, 1, 7'd0);

    // Test 6: stall, flush at 40, reset mid-stream
    do_reset();
    apply(0, 0, 1, 64'hCAFE_F00D_DEAD_BEEF, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd24);
    apply(1, 0, 1, 64'h1234_5678_9ABC_DEF0, 1, 7'd8);
    apply(1, 0, 0, '0, 0, 0);
    chk("t6_stall_b40", 64'(bus.buf_bits), 64'd40);
    apply(0, 1, 1, 64'h1234_5678_9ABC_DEF0, 1, 7'd8);
    chk("t6_flush_b0", 64'(bus.buf_bits), 64'd0);
    apply(0, 0, 1, 64'h0BAD_C0DE_0BAD_C0DE, 0, 0);
    apply(0, 0, 0, '0, 1, 7'd13);
    do_reset();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rw = {$urandom, $urandom};
      case ($urandom_range(0, 19))
        0:       rl = 7'd0;
        1:       rl = 7'($urandom_range(65, 127));
        2:       rl = 7'd64;
        3:       rl = 7'd1;
        default: rl = 7'($urandom_range(1, 64));
      endcase
      apply($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 6, rw, $urandom_range(0, 9) < 7, rl);
      if (k == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
